// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave transmitter: FSM state encoding and default frame width.
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Purpose: brings one asynchronous level into clk_i and flags its rising/falling edges.
// Latency: SYNC_STAGES cycles to the synchronized level; edge flags are valid in that same cycle.
// Backpressure: none, free-running; edge flags are single-cycle pulses.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_o = level & ~prev_q;
    assign fall_o = ~level & prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// Purpose: SPI mode-0 slave that shifts one preloaded word out on MISO, MSB first, per chip-select frame.
// Latency: MISO updates SYNC_STAGES+1 clk_i cycles after an sclk falling edge; status pulses follow the synced cs edge by one cycle.
// Backpressure: tx_ready_o is high only in IDLE; one word is held until its frame completes or aborts.
module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cs_ni,
    input  logic                  sclk_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  done_o,
    output logic                  abort_o,
    output logic                  underrun_o
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    spi_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;
    logic                  underrun_q, underrun_d;
    logic                  oe_q;
    logic                  cs_rise, cs_fall;
    logic                  sclk_rise, sclk_fall;
    logic                  last_rise;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (cs_ni),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (sclk_i),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // A rise that lands together with cs going high still completes the frame.
    assign last_rise = sclk_rise && (cnt_q == LAST_CNT);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    shreg_d    = '0;
                    cnt_d      = '0;
                    underrun_d = 1'b1;
                    state_d    = ST_SHIFT;
                end else if (tx_valid_i) begin
                    shreg_d = tx_data_i;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_fall) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cs_rise) begin
                    done_d  = last_rise;
                    abort_d = ~last_rise;
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (last_rise) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (cs_rise) begin
                    done_d  = 1'b1;
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            underrun_q <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            underrun_q <= underrun_d;
            // Tracks the synchronized cs level, inverted.
            if (cs_fall) begin
                oe_q <= 1'b1;
            end else if (cs_rise) begin
                oe_q <= 1'b0;
            end
        end
    end

    assign tx_ready_o = (state_q == ST_IDLE);
    assign miso_oe_o  = oe_q;
    assign miso_o     = oe_q & shreg_q[DATA_WIDTH-1];
    assign done_o     = done_q;
    assign abort_o    = abort_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: acts as a mode-0 SPI master at clk/8 and checks frames against a word-level model.
module tb_spi_slave_tx;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs_n;
    logic          sclk;
    logic          miso;
    logic          miso_oe;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          done;
    logic          abort;
    logic          underrun;

    always #5 clk = ~clk;

    spi_slave_tx #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cs_ni      (cs_n),
        .sclk_i     (sclk),
        .miso_o     (miso),
        .miso_oe_o  (miso_oe),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .done_o     (done),
        .abort_o    (abort),
        .underrun_o (underrun)
    );

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;
    int under_cnt = 0;

    // Word-level model: at most one word held, consumed by the next frame.
    bit            m_loaded;
    logic [DW-1:0] m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle checks: gated MISO, drive enable following a settled cs, single-cycle pulses.
    int   cs_stable = 0;
    logic cs_last   = 1'b1;
    logic done_p = 1'b0, abort_p = 1'b0, under_p = 1'b0;

    always @(posedge clk) begin
        #1;
        if (cs_n !== cs_last) cs_stable = 0;
        else if (cs_stable < 100) cs_stable++;
        cs_last = cs_n;
        chk("miso_gated", 32'(miso & ~miso_oe), 32'd0);
        if (!rst_n) chk("oe_in_reset", 32'(miso_oe), 32'd0);
        else if (cs_stable >= 4) chk("oe_follows_cs", 32'(miso_oe), 32'(!cs_n));
        if (done) begin
            chk("done_width", 32'(done_p), 32'd0);
            done_cnt++;
        end
        if (abort) begin
            chk("abort_width", 32'(abort_p), 32'd0);
            abort_cnt++;
        end
        if (underrun) begin
            chk("underrun_width", 32'(under_p), 32'd0);
            under_cnt++;
        end
        done_p  = done;
        abort_p = abort;
        under_p = underrun;
    end

    task automatic offer(input string tag, input logic [DW-1:0] d);
        bit exp_acc;
        exp_acc = !m_loaded;
        @(negedge clk);
        chk({tag, "_ready_pre"}, 32'(tx_ready), 32'(exp_acc));
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (exp_acc) begin
            m_loaded = 1'b1;
            m_word   = d;
        end
        @(negedge clk);
        chk({tag, "_ready_post"}, 32'(tx_ready), 32'(!m_loaded));
    endtask

    // Master side: nbits rising sclk edges, MISO sampled just before each rise.
    task automatic frame(input int nbits, input bit raise_cs, input bit cs_with_last,
                         output logic [31:0] got);
        got = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            got  = {got[30:0], miso};
            sclk = 1'b1;
            if (cs_with_last && i == nbits - 1) cs_n = 1'b1;
            repeat (4) @(negedge clk);
            if (!(cs_with_last && i == nbits - 1)) begin
                sclk = 1'b0;
                repeat (4) @(negedge clk);
            end
        end
        if (cs_with_last) sclk = 1'b0;
        else if (raise_cs) cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input int nbits, input bit cs_with_last,
                             input logic [DW-1:0] lit);
        logic [DW-1:0] exp_word;
        bit            exp_under;
        bit            complete;
        int            d0, a0, u0;
        logic [31:0]   got;
        exp_word  = m_loaded ? m_word : '0;
        exp_under = !m_loaded;
        complete  = (nbits == DW);
        m_loaded  = 1'b0;
        d0 = done_cnt;
        a0 = abort_cnt;
        u0 = under_cnt;
        frame(nbits, 1'b1, cs_with_last, got);
        if (complete) begin
            chk({tag, "_word_model"}, got[DW-1:0], 32'(exp_word));
            chk({tag, "_word_lit"}, got[DW-1:0], 32'(lit));
        end
        chk({tag, "_done"}, done_cnt - d0, 32'(complete));
        chk({tag, "_abort"}, abort_cnt - a0, 32'(!complete));
        chk({tag, "_underrun"}, under_cnt - u0, 32'(exp_under));
        chk({tag, "_ready_after"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          d0, a0, u0;
        logic [31:0] got;
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        sclk     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        m_loaded = 1'b0;
        m_word   = '0;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_oe", 32'(miso_oe), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        offer("a5c3", 16'hA5C3);
        run_frame("a5c3", DW, 1'b0, 16'hA5C3);

        run_frame("empty", DW, 1'b0, 16'h0000);

        offer("ffff", 16'hFFFF);
        run_frame("abort7", 7, 1'b0, 16'h0000);
        offer("1234", 16'h1234);
        run_frame("1234", DW, 1'b0, 16'h1234);

        offer("3c96", 16'h3C96);
        offer("5555", 16'h5555);
        run_frame("3c96", DW, 1'b0, 16'h3C96);

        offer("8001", 16'h8001);
        d0 = done_cnt;
        a0 = abort_cnt;
        u0 = under_cnt;
        for (int i = 0; i < 4; i++) begin
            sclk = ~sclk;
            repeat (4) @(negedge clk);
        end
        chk("idle_sclk_done", done_cnt - d0, 32'd0);
        chk("idle_sclk_abort", abort_cnt - a0, 32'd0);
        chk("idle_sclk_underrun", under_cnt - u0, 32'd0);
        chk("idle_sclk_ready", 32'(tx_ready), 32'd0);
        run_frame("8001", DW, 1'b0, 16'h8001);

        offer("beef", 16'hBEEF);
        d0 = done_cnt;
        a0 = abort_cnt;
        u0 = under_cnt;
        frame(5, 1'b0, 1'b0, got);
        chk("beef_partial", got, 32'h17);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        @(negedge clk);
        chk("midrst_miso", 32'(miso), 32'd0);
        chk("midrst_oe", 32'(miso_oe), 32'd0);
        chk("midrst_ready", 32'(tx_ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_abort", 32'(abort), 32'd0);
        chk("midrst_underrun", 32'(underrun), 32'd0);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        m_loaded = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 32'd0);
        chk("midrst_no_abort", abort_cnt - a0, 32'd0);
        chk("midrst_ready_after", 32'(tx_ready), 32'd1);
        offer("0f0f", 16'h0F0F);
        run_frame("0f0f", DW, 1'b0, 16'h0F0F);

        offer("6a6a", 16'h6A6A);
        run_frame("cs_with_last", DW, 1'b1, 16'h6A6A);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
